// File: rtl/ann_ctrl_pkg.sv
// Shared types and sizing helpers for the inference sequencing controller.
package ann_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DIVIDE,
        NEXT,
        DONE
    } seq_state_t;

    function automatic int cw_of(input int max_inputs);
        return $clog2(max_inputs + 1);
    endfunction

    // 100 < 2**7, so correct_count*100 always fits in CW+7 bits
    function automatic int dw_of(input int max_inputs);
        return cw_of(max_inputs) + 7;
    endfunction

    localparam int CW = cw_of(200);
    localparam int DW = dw_of(200);

endpackage

// File: rtl/inference_sequencer_if.sv
// Datapath-facing signal bundle of the inference sequencer.
interface inference_sequencer_if
    import ann_ctrl_pkg::*;
#(
    parameter int out_rows   = 10,
    parameter int max_inputs = 200
);
    localparam int cw = cw_of(max_inputs);

    logic                enable_inference;
    logic                upload_done;
    logic                input_loaded;
    logic                final_done;
    logic [out_rows-1:0] final_out;
    logic [out_rows-1:0] expected_value;
    logic                en_weights;
    logic                begin_next;
    logic [8:0]          accuracy;
    logic [cw-1:0]       correct_count;
    logic [cw-1:0]       count;
    logic                busy;
    logic                all_done;

    modport master (
        output enable_inference, upload_done, input_loaded,
        output final_done, final_out, expected_value,
        input  en_weights, begin_next, accuracy,
        input  correct_count, count, busy, all_done
    );

    modport slave (
        input  enable_inference, upload_done, input_loaded,
        input  final_done, final_out, expected_value,
        output en_weights, begin_next, accuracy,
        output correct_count, count, busy, all_done
    );

endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per cycle.
module seq_divider #(
    parameter int dw = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [dw-1:0] dividend,
    input  logic [dw-1:0] divisor,
    output logic          done,
    output logic [dw-1:0] quotient,
    output logic [dw-1:0] remainder
);
    localparam int iw = $clog2(dw + 1);

    logic [dw-1:0] rem_q;
    logic [dw-1:0] quo_q;
    logic [iw-1:0] iter_q;
    logic          active_q;

    logic [dw-1:0] rem_src;
    logic [dw-1:0] quo_src;
    logic [dw:0]   trial;
    logic [dw:0]   diff;
    logic          fits;
    logic          step;
    logic [iw-1:0] iter_n;
    logic [dw-1:0] rem_n;
    logic [dw-1:0] quo_n;

    // The first iteration consumes the operands directly on the start cycle
    always_comb begin
        rem_src  = active_q ? rem_q : '0;
        quo_src  = active_q ? quo_q : dividend;
        step     = start || active_q;
        trial    = {rem_src, quo_src[dw-1]};
        diff     = trial - {1'b0, divisor};
        fits     = trial >= {1'b0, divisor};
        rem_n    = fits ? diff[dw-1:0] : trial[dw-1:0];
        quo_n    = {quo_src[dw-2:0], fits};
        iter_n   = active_q ? iter_q + 1'b1 : iw'(1);
        done     = step && (iter_n == iw'(dw));
        quotient  = quo_n;
        remainder = rem_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q    <= '0;
            quo_q    <= '0;
            iter_q   <= '0;
            active_q <= 1'b0;
        end else if (step) begin
            rem_q    <= rem_n;
            quo_q    <= quo_n;
            iter_q   <= iter_n;
            active_q <= !done;
        end
    end

endmodule

// File: rtl/inference_sequencer.sv
// Sequencing FSM: gates weight enable, steps samples, scores results
// and maintains running accuracy.
module inference_sequencer
    import ann_ctrl_pkg::*;
#(
    parameter int out_rows    = 10,
    parameter int max_inputs  = 200,
    parameter int num_samples = 200
) (
    input  logic                 clk,
    input  logic                 rst_overall,
    inference_sequencer_if.slave bus
);
    localparam int seq_cw = cw_of(max_inputs);
    localparam int seq_dw = dw_of(max_inputs);

    seq_state_t state;
    seq_state_t state_n;

    logic [seq_cw-1:0] count_q;
    logic [seq_cw-1:0] correct_q;
    logic [8:0]        acc_q;
    logic              en_q;

    logic              match;
    logic              start_ok;
    logic              last_sample;
    logic              div_start;
    logic              div_done;
    logic [seq_dw-1:0] dividend;
    logic [seq_dw-1:0] divisor;
    logic [seq_dw-1:0] quotient;
    logic [8:0]        acc_sat;

    assign match       = bus.final_out == bus.expected_value;
    assign start_ok    = bus.enable_inference && bus.upload_done;
    assign last_sample = count_q == seq_cw'(num_samples);
    assign dividend    = seq_dw'(correct_q) * seq_dw'(100);
    assign divisor     = seq_dw'(count_q);
    assign div_start   = (state == DIVIDE) && (count_q != '0);
    assign acc_sat     = (quotient > seq_dw'(100)) ? 9'd100
                                                   : quotient[8:0];

    seq_divider #(
        .dw(seq_dw)
    ) u_div (
        .clk       (clk),
        .rst       (rst_overall),
        .start     (div_start),
        .dividend  (dividend),
        .divisor   (divisor),
        .done      (div_done),
        .quotient  (quotient),
        .remainder ()
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   if (start_ok) state_n = LOAD;
            LOAD:   if (bus.input_loaded) state_n = RUN;
            RUN:    if (bus.final_done) state_n = DIVIDE;
            DIVIDE: if (count_q == '0 || div_done) state_n = NEXT;
            NEXT: begin
                if (last_sample)               state_n = DONE;
                else if (bus.enable_inference) state_n = LOAD;
                else                           state_n = IDLE;
            end
            DONE:   state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_overall) begin
            state     <= IDLE;
            count_q   <= '0;
            correct_q <= '0;
            acc_q     <= '0;
            en_q      <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start_ok)
                en_q <= 1'b1;
            if (state == RUN && bus.final_done) begin
                count_q <= count_q + 1'b1;
                if (match)
                    correct_q <= correct_q + 1'b1;
            end
            if (state == DIVIDE && div_done)
                acc_q <= acc_sat;
        end
    end

    assign bus.en_weights    = en_q;
    assign bus.begin_next    = state == NEXT;
    assign bus.accuracy      = acc_q;
    assign bus.correct_count = correct_q;
    assign bus.count         = count_q;
    assign bus.busy          = (state != IDLE) && (state != DONE);
    assign bus.all_done      = state == DONE;

endmodule
